// File: rtl/band_peak_picker.sv
// Streams a spectral frame band by band and records each band's peak bin index.
// Produces a per-frame fingerprint and per-band threshold flags.
module band_peak_picker #(
    parameter int                DATA_W        = 16,
    parameter int                NUM_BANDS     = 4,
    parameter int                BINS_PER_BAND = 16,
    parameter logic [DATA_W-1:0] MAG_THRESH    = DATA_W'(64)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    input  logic                                          in_start,
    input  logic [DATA_W-1:0]                             in_data,
    output logic                                          out_valid,
    output logic [NUM_BANDS*$clog2(BINS_PER_BAND)-1:0]    out_fp,
    output logic [NUM_BANDS-1:0]                          out_band_ok,
    output logic                                          out_frame_err,
    output logic                                          busy
);
    localparam int BIN_W  = $clog2(BINS_PER_BAND);
    localparam int CNT_W  = $clog2(NUM_BANDS * BINS_PER_BAND);
    localparam int BAND_W = CNT_W - BIN_W;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(NUM_BANDS * BINS_PER_BAND - 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BINS_PER_BAND - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                              state_reg;
    logic [CNT_W-1:0]                    cnt_reg;
    logic [DATA_W-1:0]                   max_reg;
    logic [BIN_W-1:0]                    idx_reg;
    logic [NUM_BANDS-1:0][BIN_W-1:0]     res_idx_reg;
    logic [NUM_BANDS-1:0]                res_ok_reg;
    logic                                out_valid_reg;
    logic                                out_frame_err_reg;
    logic [NUM_BANDS*BIN_W-1:0]          out_fp_reg;
    logic [NUM_BANDS-1:0]                out_band_ok_reg;

    logic                                accept;
    logic                                abort;
    logic [CNT_W-1:0]                    pos;
    logic [BIN_W-1:0]                    bin;
    logic [BAND_W-1:0]                   band;
    logic [DATA_W-1:0]                   max_next;
    logic [BIN_W-1:0]                    idx_next;
    logic                                band_done;
    logic                                frame_done;
    logic                                ok_now;
    logic [NUM_BANDS*BIN_W-1:0]          fp_next;
    logic [NUM_BANDS-1:0]                ok_next;

    // A start pulse always re-bases the sample position to bin 0 of band 0.
    always_comb begin
        accept     = in_valid && (state_reg == ACCUM || in_start);
        abort      = in_valid && in_start && state_reg == ACCUM && cnt_reg != '0;
        pos        = in_start ? '0 : cnt_reg;
        bin        = pos[BIN_W-1:0];
        band       = pos[CNT_W-1:BIN_W];
        band_done  = bin == LAST_BIN;
        frame_done = pos == LAST_POS;
        max_next   = max_reg;
        idx_next   = idx_reg;
        if (bin == '0) begin
            max_next = in_data;
            idx_next = '0;
        end else if (in_data > max_reg) begin
            max_next = in_data;
            idx_next = bin;
        end
        ok_now = max_next >= MAG_THRESH;
    end

    // The band finishing on this sample is merged in so the last band needs no extra cycle.
    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_slot
            always_comb begin
                if (band_done && band == BAND_W'(gi)) begin
                    fp_next[gi*BIN_W +: BIN_W] = idx_next;
                    ok_next[gi]                = ok_now;
                end else begin
                    fp_next[gi*BIN_W +: BIN_W] = res_idx_reg[gi];
                    ok_next[gi]                = res_ok_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            max_reg           <= '0;
            idx_reg           <= '0;
            res_idx_reg       <= '0;
            res_ok_reg        <= '0;
            out_valid_reg     <= 1'b0;
            out_frame_err_reg <= 1'b0;
            out_fp_reg        <= '0;
            out_band_ok_reg   <= '0;
        end else begin
            out_valid_reg     <= 1'b0;
            out_frame_err_reg <= 1'b0;
            if (accept) begin
                max_reg           <= max_next;
                idx_reg           <= idx_next;
                out_frame_err_reg <= abort;
                if (band_done) begin
                    res_idx_reg[band] <= idx_next;
                    res_ok_reg[band]  <= ok_now;
                end
                if (frame_done) begin
                    state_reg       <= IDLE;
                    cnt_reg         <= '0;
                    out_valid_reg   <= 1'b1;
                    out_fp_reg      <= fp_next;
                    out_band_ok_reg <= ok_next;
                end else begin
                    state_reg <= ACCUM;
                    cnt_reg   <= pos + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_frame_err = out_frame_err_reg;
    assign out_fp        = out_fp_reg;
    assign out_band_ok   = out_band_ok_reg;
    assign busy          = state_reg == ACCUM;

endmodule

// File: tb/tb_band_peak_picker.sv
// Self-checking bench for band_peak_picker: directed frame table, corner sequences
// and randomized frames checked against a first-index-of-maximum model.
module tb_band_peak_picker;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_start;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_fp;
    logic [3:0]  out_band_ok;
    logic        out_frame_err;
    logic        busy;

    band_peak_picker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start),
        .in_data(in_data), .out_valid(out_valid), .out_fp(out_fp),
        .out_band_ok(out_band_ok), .out_frame_err(out_frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [15:0] frame_buf [64];

    always @(posedge clk) cycle++;
    always @(negedge clk) begin
        if (out_valid) n_valid++;
        if (out_frame_err) n_err++;
    end

    typedef struct {
        logic [5:0][5:0]  pos;
        logic [5:0][15:0] val;
        bit               stall;
        logic [15:0]      fp;
        logic [3:0]       ok;
    } vec_t;
    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit stall);
        for (int i = lo; i < hi; i++) begin
            if (stall && i > 0) begin
                idle();
                tick();
            end
            in_valid = 1'b1;
            in_start = (i == 0);
            in_data  = frame_buf[i];
            tick();
        end
    endtask

    task automatic build_vec(input int v);
        for (int i = 0; i < 64; i++) frame_buf[i] = 16'h0;
        for (int j = 0; j < 6; j++)
            if (vecs[v].val[j] != 16'h0) frame_buf[vecs[v].pos[j]] = vecs[v].val[j];
    endtask

    task automatic build_random();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 7))
                0:       frame_buf[i] = 16'($urandom);
                1, 2:    frame_buf[i] = 16'($urandom_range(55, 75));
                default: frame_buf[i] = 16'($urandom_range(0, 10));
            endcase
        end
    endtask

    // Peak = largest magnitude in the band; index = lowest bin holding that magnitude.
    function automatic void model(output logic [15:0] fp, output logic [3:0] ok);
        fp = 16'h0;
        ok = 4'h0;
        for (int b = 0; b < 4; b++) begin
            int mx = 0;
            int idx = 0;
            for (int k = 0; k < 16; k++)
                if (int'(frame_buf[b*16+k]) > mx) mx = int'(frame_buf[b*16+k]);
            for (int k = 15; k >= 0; k--)
                if (int'(frame_buf[b*16+k]) == mx) idx = k;
            fp[b*4 +: 4] = 4'(idx);
            ok[b]        = mx >= 64;
        end
    endfunction

    task automatic check_result(input string name, input logic [15:0] fp, input logic [3:0] ok);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_fp"}, 32'(out_fp), 32'(fp));
        check({name, "_ok"}, 32'(out_band_ok), 32'(ok));
    endtask

    task automatic finish_frame(input string name);
        idle();
        tick();
        check({name, "_pulse_end"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] efp;
        logic [3:0]  eok;
        logic [15:0] afp;
        logic [3:0]  aok;
        int v0, e0, ca, cb;

        vecs[0] = '{pos: {6'd0, 6'd0, 6'd56, 6'd39, 6'd22, 6'd5},
                    val: {16'h0, 16'h0, 16'h1000, 16'h1000, 16'h1000, 16'h1000},
                    stall: 1'b0, fp: 16'h8765, ok: 4'hF};
        vecs[1] = '{pos: {6'd0, 6'd48, 6'd32, 6'd23, 6'd9, 6'd3},
                    val: {16'h0, 16'hFFFF, 16'hFFFF, 16'd63, 16'h0200, 16'h0200},
                    stall: 1'b0, fp: 16'h0073, ok: 4'b1101};
        vecs[2] = '{pos: vecs[0].pos, val: vecs[0].val, stall: 1'b1, fp: 16'h8765, ok: 4'hF};
        vecs[3] = '{pos: '0, val: '0, stall: 1'b0, fp: 16'h0000, ok: 4'h0};
        vecs[4] = '{pos: {6'd0, 6'd62, 6'd33, 6'd31, 6'd16, 6'd15},
                    val: {16'h0, 16'd64, 16'hFFFF, 16'd63, 16'd63, 16'd64},
                    stall: 1'b0, fp: 16'hE10F, ok: 4'b1101};

        reset = 1'b1;
        idle();
        in_data = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_fp", 32'(out_fp), 32'h0);
        check("rst_ok", 32'(out_band_ok), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(out_frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Samples without start while idle are dropped.
        in_valid = 1'b1;
        in_start = 1'b0;
        in_data  = 16'hFFFF;
        repeat (5) tick();
        check("drop_busy", 32'(busy), 32'h0);
        check("drop_valid", 32'(n_valid), 32'h0);

        for (int v = 0; v < 5; v++) begin
            v0 = n_valid;
            build_vec(v);
            send_range(0, 64, vecs[v].stall);
            check_result($sformatf("vec%0d", v), vecs[v].fp, vecs[v].ok);
            finish_frame($sformatf("vec%0d", v));
            check($sformatf("vec%0d_count", v), 32'(n_valid - v0), 32'd1);
        end

        // Abort at sample 20, then a full frame.
        v0 = n_valid; e0 = n_err;
        build_random();
        send_range(0, 20, 1'b0);
        check("abort_busy", 32'(busy), 32'd1);
        build_vec(0);
        send_range(0, 64, 1'b0);
        check_result("abort", 16'h8765, 4'hF);
        finish_frame("abort");
        check("abort_err_cnt", 32'(n_err - e0), 32'd1);
        check("abort_valid_cnt", 32'(n_valid - v0), 32'd1);

        // Start coinciding with the 64th sample aborts the old frame.
        v0 = n_valid; e0 = n_err;
        build_random();
        send_range(0, 63, 1'b0);
        build_random();
        model(efp, eok);
        send_range(0, 64, 1'b0);
        check_result("start64", efp, eok);
        finish_frame("start64");
        check("start64_err_cnt", 32'(n_err - e0), 32'd1);
        check("start64_valid_cnt", 32'(n_valid - v0), 32'd1);

        // Mid-frame reset discards the partial frame.
        v0 = n_valid; e0 = n_err;
        build_random();
        send_range(0, 30, 1'b0);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_fp", 32'(out_fp), 32'h0);
        check("mrst_ok", 32'(out_band_ok), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        build_vec(4);
        send_range(0, 63, 1'b0);
        check("mrst_hold_fp", 32'(out_fp), 32'h0);
        check("mrst_hold_ok", 32'(out_band_ok), 32'h0);
        send_range(63, 64, 1'b0);
        check_result("mrst", 16'hE10F, 4'b1101);
        finish_frame("mrst");
        check("mrst_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("mrst_err_cnt", 32'(n_err - e0), 32'd0);

        // Back-to-back frames with no idle cycle.
        v0 = n_valid; e0 = n_err;
        build_vec(0);
        send_range(0, 64, 1'b0);
        check_result("b2b_a", 16'h8765, 4'hF);
        ca = cycle;
        build_random();
        model(efp, eok);
        send_range(0, 64, 1'b0);
        check_result("b2b_b", efp, eok);
        cb = cycle;
        finish_frame("b2b");
        check("b2b_spacing", 32'(cb - ca), 32'd64);
        check("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
        check("b2b_err_cnt", 32'(n_err - e0), 32'd0);

        // Randomized frames against the model.
        for (int r = 0; r < 8; r++) begin
            build_random();
            model(efp, eok);
            send_range(0, 64, 1'($urandom_range(0, 1)));
            check_result($sformatf("rand%0d", r), efp, eok);
            finish_frame($sformatf("rand%0d", r));
            afp = out_fp;
            aok = out_band_ok;
            repeat (3) tick();
            check($sformatf("rand%0d_hold_fp", r), 32'(out_fp), 32'(efp));
            check($sformatf("rand%0d_hold_ok", r), 32'(out_band_ok), 32'(eok));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
